// File: rtl/alu_pkg.sv
// Shared opcode encodings and width default for the 64-bit RISC-V ALU.
// Optional feature macro used across this slice: ALU_OVERFLOW_EN.
package alu_pkg;

    localparam int ALU_WIDTH = 64;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

endpackage

// File: rtl/riscv_alu64_if.sv
// Operand/result bundle between the execute stage and the ALU.
// The overflow signal exists only when ALU_OVERFLOW_EN is defined.
interface riscv_alu64_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
);

    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [3:0]       aluControl;
    logic             in_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             out_valid;
`ifdef ALU_OVERFLOW_EN
    logic             overflow;
`endif

    modport master (
        output x,
        output y,
        output aluControl,
        output in_valid,
        input  result,
        input  zero,
        input  out_valid
`ifdef ALU_OVERFLOW_EN
        ,
        input  overflow
`endif
    );

    modport slave (
        input  x,
        input  y,
        input  aluControl,
        input  in_valid,
        output result,
        output zero,
        output out_valid
`ifdef ALU_OVERFLOW_EN
        ,
        output overflow
`endif
    );

endinterface

// File: rtl/alu_comb.sv
// Purely combinational ALU op mux: next result and signed overflow.
// Overflow logic is built only when ALU_OVERFLOW_EN is defined.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [3:0]       ctrl,
    output logic [WIDTH-1:0] res
`ifdef ALU_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             lt_s;
    logic             lt_u;

    assign shamt = y[SHW-1:0];
    assign sum   = x + y;
    assign diff  = x - y;
    assign lt_s  = $signed(x) < $signed(y);
    assign lt_u  = x < y;

    // Select the operation result; unknown codes produce zero.
    always_comb begin
        res = '0;
        case (ctrl)
            ALU_AND:  res = x & y;
            ALU_OR:   res = x | y;
            ALU_ADD:  res = sum;
            ALU_XOR:  res = x ^ y;
            ALU_SLL:  res = x << shamt;
            ALU_SRL:  res = x >> shamt;
            ALU_SUB:  res = diff;
            ALU_SLT:  res = {{(WIDTH-1){1'b0}}, lt_s};
            ALU_SLTU: res = {{(WIDTH-1){1'b0}}, lt_u};
            ALU_SRA:  res = $unsigned($signed(x) >>> shamt);
            ALU_NOR:  res = ~(x | y);
            default:  res = '0;
        endcase
    end

`ifdef ALU_OVERFLOW_EN
    // Signed overflow is meaningful only for ADD and SUB.
    always_comb begin
        ovf = 1'b0;
        if (ctrl == ALU_ADD) begin
            ovf = (x[WIDTH-1] == y[WIDTH-1]) &&
                  (sum[WIDTH-1] != x[WIDTH-1]);
        end else if (ctrl == ALU_SUB) begin
            ovf = (x[WIDTH-1] != y[WIDTH-1]) &&
                  (diff[WIDTH-1] != x[WIDTH-1]);
        end
    end
`endif

endmodule

// File: rtl/riscv_alu64.sv
// Registered 64-bit ALU for the execute stage, one cycle of latency.
// Optional signed-overflow output enabled by ALU_OVERFLOW_EN.
module riscv_alu64
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input logic          clk,
    input logic          rst,
    riscv_alu64_if.slave bus
);

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] result_q;
    logic             zero_d;
    logic             zero_q;
    logic             out_valid_d;
    logic             out_valid_q;
`ifdef ALU_OVERFLOW_EN
    logic             alu_ovf;
    logic             overflow_d;
    logic             overflow_q;
`endif

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_alu_comb (
        .x    (bus.x),
        .y    (bus.y),
        .ctrl (bus.aluControl),
        .res  (alu_res)
`ifdef ALU_OVERFLOW_EN
        ,
        .ovf  (alu_ovf)
`endif
    );

    // Capture a new result when valid, otherwise hold it.
    always_comb begin
        result_d    = result_q;
        zero_d      = zero_q;
        out_valid_d = bus.in_valid;
`ifdef ALU_OVERFLOW_EN
        overflow_d  = overflow_q;
`endif
        if (bus.in_valid) begin
            result_d   = alu_res;
            zero_d     = (alu_res == '0);
`ifdef ALU_OVERFLOW_EN
            overflow_d = alu_ovf;
`endif
        end
    end

    // Output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q    <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef ALU_OVERFLOW_EN
            overflow_q  <= 1'b0;
`endif
        end else begin
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
`ifdef ALU_OVERFLOW_EN
            overflow_q  <= overflow_d;
`endif
        end
    end

    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.out_valid = out_valid_q;
`ifdef ALU_OVERFLOW_EN
    assign bus.overflow  = overflow_q;
`endif

endmodule

// File: tb/tb_riscv_alu64.sv
// Scoreboard bench for riscv_alu64 (covers ALU_OVERFLOW_EN when defined).
// Expectations are queued on drive and popped each cycle at negedge.
module tb_riscv_alu64;

    typedef struct {
        logic        v;
        logic [63:0] r;
        logic        z;
        logic        o;
    } exp_t;

    logic clk;
    logic rst;

    riscv_alu64_if #(.WIDTH(64)) bus ();

    riscv_alu64 #(.WIDTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [63:0] last_r = 64'd0;
    logic        last_o = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Apply one cycle of inputs and queue what should appear after the edge.
    task automatic step(input logic r, input logic v, input logic [3:0] op,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] er, input logic eo);
        exp_t e;
        rst            = r;
        bus.in_valid   = v;
        bus.aluControl = op;
        bus.x          = a;
        bus.y          = b;
        if (r) begin
            last_r = 64'd0;
            last_o = 1'b0;
        end else if (v) begin
            last_r = er;
            last_o = eo;
        end
        e.v = v & ~r;
        e.r = last_r;
        e.z = (last_r == 64'd0);
        e.o = last_o;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [3:0] c, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] er,
                      input logic eo);
        step(1'b0, 1'b1, c, a, b, er, eo);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'h2, 64'hDEAD, 64'hBEEF, 64'd0, 1'b0);
    endtask

    function automatic logic [63:0] model(input logic [3:0] c,
                                          input logic [63:0] a,
                                          input logic [63:0] b);
        logic [63:0] r;
        int          s;
        s = int'(b[5:0]);
        r = 64'd0;
        if (c == 4'd0) r = a & b;
        if (c == 4'd1) r = a | b;
        if (c == 4'd2) r = a + b;
        if (c == 4'd3) r = a ^ b;
        if (c == 4'd4) r = a << s;
        if (c == 4'd5) r = a >> s;
        if (c == 4'd6) r = a - b;
        if (c == 4'd7) r = {63'd0, $signed(a) < $signed(b)};
        if (c == 4'd8) r = {63'd0, a < b};
        if (c == 4'd9) r = $unsigned($signed(a) >>> s);
        if (c == 4'd12) r = ~(a | b);
        return r;
    endfunction

    function automatic logic model_ovf(input logic [3:0] c,
                                       input logic [63:0] a,
                                       input logic [63:0] b);
        logic [63:0] s;
        s = model(c, a, b);
        if (c == 4'd2) return (a[63] == b[63]) && (s[63] != a[63]);
        if (c == 4'd6) return (a[63] != b[63]) && (s[63] != a[63]);
        return 1'b0;
    endfunction

    // Pop one expectation per cycle and compare all outputs.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("out_valid", {63'd0, bus.out_valid}, {63'd0, e.v});
            chk("result", bus.result, e.r);
            chk("zero", {63'd0, bus.zero}, {63'd0, e.z});
`ifdef ALU_OVERFLOW_EN
            chk("overflow", {63'd0, bus.overflow}, {63'd0, e.o});
`endif
        end
    end

    initial begin
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  c;
        logic [3:0]  ops [11];
        ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
                4'd6, 4'd7, 4'd8, 4'd9, 4'd12};

        step(1'b1, 1'b1, 4'h2, 64'h1, 64'h1, 64'd0, 1'b0);
        step(1'b1, 1'b1, 4'h2, 64'h1, 64'h1, 64'd0, 1'b0);

        op(4'b0010, 64'h1944224622462246, 64'h1D688A59188A8E91,
           64'h36ACAC9F3AD0B0D7, 1'b0);
        op(4'b0110, 64'h1944224622462246, 64'h1D688A59188A8E91,
           64'hFBDB97ED09BB93B5, 1'b0);
        op(4'b0110, 64'h5, 64'h5, 64'h0, 1'b0);
        op(4'b0111, 64'hFFFFFFFFFFFFFFFF, 64'h1, 64'h1, 1'b0);
        op(4'b1000, 64'hFFFFFFFFFFFFFFFF, 64'h1, 64'h0, 1'b0);
        op(4'b0100, 64'h8000000000000001, 64'h41,
           64'h0000000000000002, 1'b0);
        op(4'b0101, 64'h8000000000000001, 64'h41,
           64'h4000000000000000, 1'b0);
        op(4'b1001, 64'h8000000000000001, 64'h41,
           64'hC000000000000000, 1'b0);
        op(4'b0100, 64'h8000000000000001, 64'h40,
           64'h8000000000000001, 1'b0);
        op(4'b0100, 64'h8000000000000001, 64'h3F,
           64'h8000000000000000, 1'b0);
        op(4'b0101, 64'h8000000000000001, 64'h3F, 64'h1, 1'b0);
        op(4'b1001, 64'h8000000000000001, 64'h3F,
           64'hFFFFFFFFFFFFFFFF, 1'b0);
        op(4'b0000, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0);
        op(4'b0001, 64'hF0F0, 64'hFF00, 64'hFFF0, 1'b0);
        op(4'b0011, 64'hF0F0, 64'hFF00, 64'h0FF0, 1'b0);
        op(4'b1100, 64'hF0F0, 64'hFF00, 64'hFFFFFFFFFFFF000F, 1'b0);
        op(4'b1010, 64'h1234, 64'h5678, 64'h0, 1'b0);
        op(4'b1111, 64'h1234, 64'h5678, 64'h0, 1'b0);

        op(4'b0010, 64'h7FFFFFFFFFFFFFFF, 64'h1,
           64'h8000000000000000, 1'b1);
        idle();
        idle();
        op(4'b0110, 64'h8000000000000000, 64'h1,
           64'h7FFFFFFFFFFFFFFF, 1'b1);
        op(4'b0010, 64'h8000000000000000, 64'h8000000000000000,
           64'h0, 1'b1);

        step(1'b1, 1'b1, 4'b0010, 64'h3, 64'h4, 64'd0, 1'b0);
        idle();

        for (int i = 0; i < 40; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            c = ops[$urandom_range(0, 10)];
            if (i % 7 == 3) idle();
            op(c, a, b, model(c, a, b), model_ovf(c, a, b));
        end

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
        #1;
        chk("drain", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/riscv_alu64.md
Name: riscv_alu64

Overview:
64-bit integer ALU for the RISC-V datapath execute stage. Computes one of a set of arithmetic, logic, shift and compare operations on two 64-bit operands, selected by a 4-bit control code. Result and zero flag are registered, giving one cycle of latency. Used for R/I-type ops and for branch compare via the zero flag.

Parameters:
WIDTH, 64, operand/result width (the design and tests target 64; shift amount uses log2(WIDTH) bits).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous active-high reset.
x  in  WIDTH  operand A.
y  in  WIDTH  operand B; y[5:0] is the shift amount for shifts.
aluControl  in  4  operation select.
in_valid  in  1  operands/control valid this cycle.
result  out  WIDTH  registered result.
zero  out  1  registered; 1 when result == 0.
out_valid  out  1  registered copy of in_valid.
overflow  out  1  signed overflow for ADD/SUB; only present with ALU_OVERFLOW_EN.

Behaviour:
- Reset (rst=1 at rising clk): result=0, zero=1, out_valid=0, overflow=0. Reset wins over in_valid in the same cycle; any op in flight is discarded.
- Latency 1: when in_valid=1 at edge N, result, zero and out_valid reflect those inputs after edge N.
- When in_valid=0: result and zero hold their previous values; out_valid=0.
- Opcodes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD (mod 2^64)
  - 0011 XOR
  - 0100 SLL
  - 0101 SRL
  - 0110 SUB x-y (mod 2^64)
  - 0111 SLT (signed x<y -> 1 else 0)
  - 1000 SLTU (unsigned)
  - 1001 SRA (arithmetic)
  - 1100 NOR
  - All other codes -> result 0.
- Shifts use y[5:0] only; shift by 0 returns x; shift by 63 is legal.
- Carry-out and borrow are discarded.
- zero is computed from the same value being registered into result. It is not delayed a further cycle.
- No stall or backpressure; a new op may be issued every cycle.

Optional Feature:
ALU_OVERFLOW_EN:
- Defined: the overflow port exists. Its value is registered with result.
  - ADD: set when x and y have the same sign and the result sign differs.
  - SUB: set when x and y differ in sign and the result sign differs from x.
  - All other ops: 0.
- Undefined: no overflow port and no overflow logic.

Decomposition:
- Shared package alu_pkg holds the 4-bit opcode localparams/enum (ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_SRA, ALU_NOR) and the WIDTH default.
- One natural sub-module: alu_comb, a purely combinational op mux producing next result and overflow. The top level adds the registers and the valid pipeline.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1 -> result=0, zero=1, out_valid=0.
- ADD: x=0x1944224622462246, y=0x1D688A59188A8E91, ctrl=0010 -> next cycle result=0x36ACAC9F3AD0B0D7, zero=0, out_valid=1, overflow=0.
- SUB: same x,y, ctrl=0110 -> result=0xFBDB97ED09BB93B5, zero=0, overflow=0. Then x=y=0x5 with SUB -> result=0, zero=1.
- Compare: x=0xFFFFFFFFFFFFFFFF, y=1:
  - SLT -> result=1.
  - SLTU -> result=0.
- Shifts: x=0x8000000000000001, y=0x41 (amount 1):
  - SLL -> 0x0000000000000002.
  - SRL -> 0x4000000000000000.
  - SRA -> 0xC000000000000000.
- Overflow (with ALU_OVERFLOW_EN) and hold: x=0x7FFFFFFFFFFFFFFF, y=1, ADD -> result=0x8000000000000000, overflow=1. Then in_valid=0 for 2 cycles -> result holds, out_valid=0.
